// File: rtl/countdown_pkg.sv
// Shared types, constants and helpers for the countdown controller.
// Contents:
//   state_e       - controller state encoding (StIdle, StRun, StPause, StDone)
//   BcdZero       - BCD 00
//   BcdMaxMiao    - BCD 59, the largest seconds value
//   BcdNine       - BCD 09, the largest single digit
//   bcd_sanitise  - clamps each nibble to 9, then clamps the whole value to a ceiling
package countdown_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  localparam logic [7:0] BcdZero    = 8'h00;
  localparam logic [7:0] BcdMaxMiao = 8'h59;
  localparam logic [7:0] BcdNine    = 8'h09;

  // Valid two-digit BCD compares correctly as plain binary, so the ceiling
  // check is an ordinary unsigned compare once both digits are clamped.
  function automatic logic [7:0] bcd_sanitise(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] s;
    s[7:4] = (v[7:4] > BcdNine[3:0]) ? BcdNine[3:0] : v[7:4];
    s[3:0] = (v[3:0] > BcdNine[3:0]) ? BcdNine[3:0] : v[3:0];
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/bcd_dec2.sv
// Two-digit BCD decrement by one.
// Ports:
//   d      - 8-bit BCD input value
//   q      - d minus one in BCD; 00 wraps to 59
//   borrow - high when d is 00 (the 00 -> 59 wrap)
module bcd_dec2
  import countdown_pkg::*;
(
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       borrow
);

  always_comb begin
    q      = d;
    borrow = 1'b0;
    if (d == BcdZero) begin
      q      = BcdMaxMiao;
      borrow = 1'b1;
    end else if (d[3:0] == 4'd0) begin
      q = {d[7:4] - 4'd1, BcdNine[3:0]};
    end else begin
      q = {d[7:4], d[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Minutes:seconds BCD countdown timer with optional alarm.
// Optional feature: define COUNTDOWN_BUZZ_EN to enable the alarm counter and buzz
// output; otherwise buzz is tied low.
// Parameters:
//   ALARM_SECS - number of 1 Hz ticks buzz stays high after reaching 00:00
//   MAX_FEN    - largest accepted BCD minutes preset
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   tick_1hz                 - one-cycle pulse per second
//   start, pause, clear      - one-cycle command pulses (clear > pause > start)
//   preset_fen, preset_miao  - BCD preset, sanitised when loaded
//   fen, miao                - current BCD countdown value
//   running, done            - high in RUN / DONE respectively
//   buzz                     - alarm drive
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned ALARM_SECS = 3,
  parameter logic [7:0]  MAX_FEN    = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [7:0] preset_fen,
  input  logic [7:0] preset_miao,
  output logic [7:0] fen,
  output logic [7:0] miao,
  output logic       running,
  output logic       done,
  output logic       buzz
);

  state_e     state_q, state_d;
  logic [7:0] fen_q, fen_d, miao_q, miao_d;

  logic [7:0] load_fen, load_miao;
  logic       load_zero;
  logic [7:0] miao_dec, fen_dec;
  logic       miao_borrow, fen_borrow;
  logic [7:0] fen_tick, miao_tick;
  logic       tick_zero;

  assign load_fen  = bcd_sanitise(preset_fen, MAX_FEN);
  assign load_miao = bcd_sanitise(preset_miao, BcdMaxMiao);
  assign load_zero = (load_fen == BcdZero) && (load_miao == BcdZero);

  bcd_dec2 u_dec_miao (
    .d      (miao_q),
    .q      (miao_dec),
    .borrow (miao_borrow)
  );

  bcd_dec2 u_dec_fen (
    .d      (fen_q),
    .q      (fen_dec),
    .borrow (fen_borrow)
  );

  // 00:00 holds rather than wrapping the minutes to 59.
  always_comb begin
    fen_tick  = fen_q;
    miao_tick = miao_q;
    if (!(miao_borrow && fen_borrow)) begin
      miao_tick = miao_dec;
      if (miao_borrow) fen_tick = fen_dec;
    end
  end

  assign tick_zero = (fen_tick == BcdZero) && (miao_tick == BcdZero);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      fen_q   <= BcdZero;
      miao_q  <= BcdZero;
    end else begin
      state_q <= state_d;
      fen_q   <= fen_d;
      miao_q  <= miao_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fen_d   = fen_q;
    miao_d  = miao_q;
    if (clear) begin
      state_d = StIdle;
      fen_d   = load_fen;
      miao_d  = load_miao;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // A tick coinciding with the load is deliberately not applied.
          if (start) begin
            fen_d   = load_fen;
            miao_d  = load_miao;
            state_d = load_zero ? StDone : StRun;
          end
        end
        StRun: begin
          if (pause) begin
            state_d = StPause;
          end else if (tick_1hz) begin
            fen_d  = fen_tick;
            miao_d = miao_tick;
            if (tick_zero) state_d = StDone;
          end
        end
        StPause: begin
          if (start) state_d = StRun;
        end
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef COUNTDOWN_BUZZ_EN
  localparam int unsigned AlarmW = (ALARM_SECS < 1) ? 1 : $clog2(ALARM_SECS + 1);

  logic [AlarmW-1:0] alarm_q, alarm_d;
  logic              done_entry;

  // Re-entering DONE via start with a zero preset also restarts the alarm.
  assign done_entry = (state_d == StDone) && ((state_q != StDone) || start);

  always_comb begin
    alarm_d = alarm_q;
    if (state_d != StDone) begin
      alarm_d = '0;
    end else if (done_entry) begin
      alarm_d = AlarmW'(ALARM_SECS);
    end else if (tick_1hz && (alarm_q != '0)) begin
      alarm_d = alarm_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) alarm_q <= '0;
    else     alarm_q <= alarm_d;
  end
`else
  logic unused_alarm_secs;
  assign unused_alarm_secs = ^ALARM_SECS;
`endif

  always_comb begin
    fen     = fen_q;
    miao    = miao_q;
    running = (state_q == StRun);
    done    = (state_q == StDone);
`ifdef COUNTDOWN_BUZZ_EN
    buzz    = (state_q == StDone) && (alarm_q != '0);
`else
    buzz    = 1'b0;
`endif
  end

endmodule
